// File: rtl/seq_event_monitor.sv
// seq_event_monitor: windowed edge counter with threshold alarm after a detector.
// Define SEQ_MON_STICKY_ALARM_EN to hold alarm across windows until clr or rst.
module seq_event_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             detect,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] last_count,
  output logic             win_done,
  output logic             alarm
);

  localparam int TMR_W = 16;

  localparam logic [CNT_W:0] CNT_MAX =
    {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] THR =
    (CNT_W+1)'(THRESH);
  localparam logic [TMR_W-1:0] T_END =
    TMR_W'(WIN_LEN - 1);

`ifdef SEQ_MON_STICKY_ALARM_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  generate
    if (THRESH < 1 || THRESH > (2**CNT_W) - 1 ||
        WIN_LEN < 2 || WIN_LEN > 65535) begin : g_bad_cfg
      $error("seq_event_monitor: illegal THRESH/WIN_LEN");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic               done_q, done_d;
  logic               alarm_q, alarm_d;
  logic               det_q;

  logic               ev;
  logic [CNT_W:0]     sum;
  logic [CNT_W-1:0]   sat;
  logic               hit;

  always_comb begin
    ev  = detect & ~det_q;
    sum = {1'b0, count_q} + {{CNT_W{1'b0}}, ev};
    sat = (sum > CNT_MAX) ? count_q : sum[CNT_W-1:0];
    // unsaturated compare so a saturated count never re-hits
    hit = (sum == THR);

    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    last_d  = last_q;
    done_d  = 1'b0;
    alarm_d = alarm_q;

    if (clr) begin
      state_d = IDLE;
      timer_d = '0;
      count_d = '0;
      last_d  = '0;
      alarm_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_d = hit ? ALARM : RUN;
            timer_d = '0;
            count_d = sat;
            if (hit) alarm_d = 1'b1;
          end
        end
        default: begin
          if (timer_q == T_END) begin
            last_d  = sat;
            done_d  = 1'b1;
            count_d = '0;
            timer_d = '0;
            state_d = en ? RUN : IDLE;
            alarm_d = STICKY & alarm_q;
          end else if (!en) begin
            state_d = IDLE;
            count_d = '0;
            timer_d = '0;
            alarm_d = STICKY & alarm_q;
          end else begin
            timer_d = timer_q + 16'd1;
            count_d = sat;
            if (state_q == RUN && hit) begin
              state_d = ALARM;
              alarm_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      count_q <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      count_q <= count_d;
      last_q  <= last_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
      det_q   <= detect;
    end
  end

  assign count      = count_q;
  assign last_count = last_q;
  assign win_done   = done_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_seq_event_monitor.sv
// Directed bench for seq_event_monitor: default instance plus
// a 2-bit counter instance sharing stimulus to exercise saturation.
module tb_seq_event_monitor;

  localparam int THRESH = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic       detect;
  logic [7:0] count;
  logic [7:0] last_count;
  logic       win_done;
  logic       alarm;
  logic [1:0] count2;
  logic [1:0] last_count2;
  logic       win_done2;
  logic       alarm2;

  int checks = 0;
  int errors = 0;

  logic prev_det;
  logic sticky_flag;
  int   last_exp;

  always #5 clk = ~clk;

  seq_event_monitor #(
    .CNT_W(8), .WIN_LEN(16), .THRESH(3)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .detect(detect), .count(count),
    .last_count(last_count), .win_done(win_done),
    .alarm(alarm)
  );

  seq_event_monitor #(
    .CNT_W(2), .WIN_LEN(16), .THRESH(3)
  ) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .detect(detect), .count(count2),
    .last_count(last_count2), .win_done(win_done2),
    .alarm(alarm2)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic int stk();
`ifdef SEQ_MON_STICKY_ALARM_EN
    return int'(sticky_flag);
`else
    return 0;
`endif
  endfunction

  task automatic check_all(input string tag, input int e_cnt,
                           input int e_last, input int e_done,
                           input int e_alarm);
    chk({tag, ".count"}, int'(count), e_cnt);
    chk({tag, ".last"}, int'(last_count), e_last);
    chk({tag, ".done"}, int'(win_done), e_done);
    chk({tag, ".alarm"}, int'(alarm), e_alarm);
    chk({tag, ".count2"}, int'(count2), sat3(e_cnt));
    chk({tag, ".last2"}, int'(last_count2), sat3(e_last));
    chk({tag, ".done2"}, int'(win_done2), e_done);
    chk({tag, ".alarm2"}, int'(alarm2), e_alarm);
  endtask

  // Runs n cycles of a window from timer 0; pat[k] is detect at timer k.
  task automatic run(input string tag, input logic [15:0] pat,
                     input int n, input int e_last);
    int cnt;
    int a;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      detect = pat[k];
      if (detect && !prev_det) cnt++;
      prev_det = detect;
      tick();
      if (k == 15) begin
        chk({tag, ".model"}, cnt, e_last);
        last_exp = e_last;
        check_all($sformatf("%s.end", tag), 0, last_exp,
                  1, stk());
      end else begin
        if (cnt >= THRESH) sticky_flag = 1'b1;
        a = (cnt >= THRESH) ? 1 : stk();
        check_all($sformatf("%s.k%0d", tag, k), cnt,
                  last_exp, 0, a);
      end
    end
    detect = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    detect = 1'b0;
    prev_det = 1'b0;
    sticky_flag = 1'b0;
    last_exp = 0;

    tick();
    tick();
    check_all("reset", 0, 0, 0, 0);

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      detect = (i % 2 == 0);
      prev_det = detect;
      tick();
      check_all($sformatf("idle%0d", i), 0, 0, 0, 0);
    end
    detect = 1'b0;
    prev_det = 1'b0;
    tick();

    en = 1'b1;
    tick();
    check_all("start", 0, 0, 0, 0);
    run("t2", 16'h0444, 16, 3);
    run("tz", 16'h0000, 16, 0);
    run("t3", 16'h023E, 16, 2);
    run("t4", 16'h8000, 16, 1);

    run("t5a", 16'h000A, 8, 0);
    en = 1'b0;
    prev_det = 1'b0;
    tick();
    check_all("endrop", 0, 1, 0, stk());
    tick();
    check_all("endrop2", 0, 1, 0, stk());

    en = 1'b1;
    tick();
    check_all("start2", 0, 1, 0, stk());
    run("t5b", 16'h0002, 5, 0);
    clr = 1'b1;
    prev_det = 1'b0;
    tick();
    sticky_flag = 1'b0;
    last_exp = 0;
    check_all("clr", 0, 0, 0, 0);
    clr = 1'b0;
    en = 1'b0;
    tick();
    check_all("clr2", 0, 0, 0, 0);

    en = 1'b1;
    tick();
    check_all("start3", 0, 0, 0, 0);
    run("sat", 16'h0555, 16, 6);

    run("arst", 16'h0001, 4, 0);
    #2;
    rst = 1'b0;
    #1;
    sticky_flag = 1'b0;
    last_exp = 0;
    check_all("arst", 0, 0, 0, 0);
    en = 1'b0;
    prev_det = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_all("arst2", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_event_monitor.md
Name: seq_event_monitor

Overview:
- Downstream consumer of the 101 sequence detector's `generated` output.
- Counts detection events over a fixed window of clock cycles and reports the per-window event count.
- Raises `alarm` when the count reaches a threshold inside the window.
- Used as the statistics/alarm stage after any Moore-style sequence detector in the FSM set.

Parameters:
- CNT_W, 8: width of event counters; count saturates at 2^CNT_W-1.
- WIN_LEN, 16: window length in clock cycles; legal range 2..65535.
- THRESH, 3: event count that raises `alarm`; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; rst=0 forces the reset state immediately.
- en  input  1  monitor enable; a window runs only while high.
- clr  input  1  synchronous clear; priority over en and detect.
- detect  input  1  detector output (`generated`); level input, counted on the rising edge.
- count  output  CNT_W  running event count for the current window.
- last_count  output  CNT_W  count latched at the end of the most recent completed window.
- win_done  output  1  one-cycle pulse in the cycle after the final window cycle.
- alarm  output  1  threshold reached in the current window.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timer=0, count=0, last_count=0, win_done=0, alarm=0, detect_d=0.
- Edge detect: detect_d is registered every cycle. An event is detect=1 && detect_d=0. A level held high for several cycles counts once.
- All outputs are registered. count and alarm change one cycle after the sampled event edge.
- FSM states:
  - IDLE: no counting. On en=1, go to RUN with timer=0, count=0. An edge in that same cycle is counted.
  - RUN: each cycle, timer increments and count increments on an event, saturating. If count+event == THRESH, go to ALARM.
  - ALARM: alarm=1. Counting and timer continue exactly as in RUN.
- Window end: the cycle with timer==WIN_LEN-1 in RUN or ALARM. An event in this cycle counts toward this window. Next cycle:
  - last_count = final count, win_done=1, alarm=0, count=0, timer=0.
  - State goes to RUN if en=1, otherwise IDLE.
- Windows run back-to-back with no gap cycle.
- en falls mid-window: next cycle go to IDLE, count=0, timer=0, alarm=0. No win_done; last_count unchanged.
- clr=1: next cycle go to IDLE with timer=0, count=0, last_count=0, alarm=0, win_done=0, regardless of en or detect. If en=1 and clr=0 afterwards, a new window starts.
- Saturation: count holds at 2^CNT_W-1. Alarm is unaffected if already set.
- THRESH > 2^CNT_W-1 or WIN_LEN < 2 is illegal; flag with a simulation $error at elaboration.
- Async reset asserted mid-window: immediate return to reset values; no partial win_done.

Optional Feature:
- Macro: SEQ_MON_STICKY_ALARM_EN.
- Defined: alarm is sticky. It stays 1 across window boundaries and en deassertion until clr=1 or rst=0. The state after window end is still RUN or IDLE; only the alarm register is held.
- Undefined: alarm clears at window end, on en falling, and on clr, as described in Behaviour.

Test Plan:
1. rst=0 for 2 cycles, then rst=1, en=0, detect toggling → all outputs 0, state IDLE, no win_done.
2. en=1, detect pulses (1 cycle high) at window cycles 2, 6, 10 → count reaches 3 at cycle 11; alarm rises the same cycle; at cycle 16, last_count=3, win_done=1 for 1 cycle, alarm=0, count=0.
3. detect held high for 5 cycles within a window, plus one later pulse → count=2, no alarm; last_count=2 at window end.
4. Pulse on timer==15 (last window cycle) → included in last_count; the next window starts with count=0.
5. en dropped at timer=8 with count=2 → IDLE next cycle, count=0, no win_done, last_count keeps its prior value. Separately, clr at timer=5 → everything including last_count is 0.
6. With SEQ_MON_STICKY_ALARM_EN: trigger alarm in window 1, then zero events in window 2 → alarm stays 1 through window 2 until clr=1. Also CNT_W=2, THRESH=3, 6 events → count saturates at 3.
